// File: rtl/program_loader_if.sv
// Stream-in and memory-write bus for the boot-time program loader.
//   in_valid/in_data/in_last : producer -> loader instruction stream
//   in_ready                 : loader -> producer accept indication
//   mem_waddr/mem_wdata/mem_wen : loader -> main memory write port
interface program_loader_if;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        in_ready;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_wen;

    // Producer / memory side (testbench or upstream fabric)
    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, mem_waddr, mem_wdata, mem_wen
    );

    // Loader side
    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, mem_waddr, mem_wdata, mem_wen
    );
endinterface

// File: rtl/program_loader.sv
// Boot-time instruction loader. Streams 32-bit words into main memory and
// holds the cpu in reset until the last word has landed plus a guard delay.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   bus         : program_loader_if.slave (input stream + memory write port)
//   cpu_rst     : reset to cpu, low once the program is loaded
//   done        : program loaded and cpu released
//   error       : DEPTH words accepted without in_last
//   word_count  : words accepted so far (saturates at DEPTH)
module program_loader #(
    parameter int unsigned DEPTH         = 2048,
    parameter int unsigned BASE_ADDR     = 0,
    parameter int unsigned RELEASE_DELAY = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    program_loader_if.slave         bus,
    output logic                    cpu_rst,
    output logic                    done,
    output logic                    error,
    output logic [$clog2(DEPTH):0]  word_count
);
    localparam int unsigned WCW = $clog2(DEPTH) + 1;
    localparam int unsigned DW  = $clog2(RELEASE_DELAY + 1);

    typedef enum logic [1:0] {ST_LOAD, ST_HOLD, ST_RUN, ST_ERROR} state_t;

    state_t          state, state_n;
    logic [DW-1:0]   dly, dly_n;
    logic [WCW-1:0]  wc_n;
    logic [31:0]     waddr_n, wdata_n;
    logic            wen_n, ready_n, cpu_rst_n, done_n, error_n;
    logic            accept_c;

    assign accept_c = bus.in_valid && bus.in_ready && (state == ST_LOAD);

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_LOAD;
            dly           <= '0;
            word_count    <= '0;
            bus.mem_waddr <= '0;
            bus.mem_wdata <= '0;
            bus.mem_wen   <= 1'b0;
            bus.in_ready  <= 1'b1;
            cpu_rst       <= 1'b1;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            state         <= state_n;
            dly           <= dly_n;
            word_count    <= wc_n;
            bus.mem_waddr <= waddr_n;
            bus.mem_wdata <= wdata_n;
            bus.mem_wen   <= wen_n;
            bus.in_ready  <= ready_n;
            cpu_rst       <= cpu_rst_n;
            done          <= done_n;
            error         <= error_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n = state;
        dly_n   = dly;
        wc_n    = word_count;
        waddr_n = bus.mem_waddr;
        wdata_n = bus.mem_wdata;
        wen_n   = 1'b0;

        case (state)
            ST_LOAD: begin
                if (accept_c) begin
                    wen_n   = 1'b1;
                    waddr_n = BASE_ADDR + 32'(word_count);
                    wdata_n = bus.in_data;
                    wc_n    = (word_count == WCW'(DEPTH)) ? word_count
                                                          : word_count + WCW'(1);
                    // in_last filling the final slot is a legal end, not an overflow
                    if (bus.in_last) begin
                        state_n = ST_HOLD;
                        dly_n   = DW'(RELEASE_DELAY);
                    end else if (word_count == WCW'(DEPTH - 1)) begin
                        state_n = ST_ERROR;
                    end
                end
            end
            ST_HOLD: begin
                // Counter hits zero RELEASE_DELAY edges after the last write;
                // the RUN transition one edge later drops cpu_rst.
                if (dly == '0) begin
                    state_n = ST_RUN;
                end else begin
                    dly_n = dly - DW'(1);
                end
            end
            ST_RUN:   state_n = ST_RUN;
            ST_ERROR: state_n = ST_ERROR;
            default:  state_n = ST_LOAD;
        endcase

        ready_n   = (state_n == ST_LOAD);
        cpu_rst_n = (state_n != ST_RUN);
        done_n    = (state_n == ST_RUN);
        error_n   = (state_n == ST_ERROR);
    end
endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader (DEPTH=8, BASE_ADDR=0, RELEASE_DELAY=4).
module tb_program_loader;
    logic       clk;
    logic       rst;
    logic       cpu_rst, done, error;
    logic [3:0] word_count;
    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    int unsigned q_addr[$];
    int unsigned q_data[$];
    int          q_cyc[$];

    program_loader_if bus ();

    program_loader #(.DEPTH(8), .BASE_ADDR(0), .RELEASE_DELAY(4)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave),
        .cpu_rst(cpu_rst), .done(done), .error(error), .word_count(word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Write capture; each mem_wen pulse spans one full period, so one negedge per write
    always @(negedge clk) begin
        if (bus.mem_wen === 1'b1) begin
            q_addr.push_back(bus.mem_waddr);
            q_data.push_back(bus.mem_wdata);
            q_cyc.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_data = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic clear_q();
        q_addr.delete(); q_data.delete(); q_cyc.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%0h exp=1", bus.in_ready); end
        checks++; if (bus.mem_wen !== 1'b0) begin failures++; $display("FAIL rst_mem_wen got=%0h exp=0", bus.mem_wen); end
        checks++; if (bus.mem_waddr !== 32'h0) begin failures++; $display("FAIL rst_mem_waddr got=%0h exp=0", bus.mem_waddr); end
        checks++; if (bus.mem_wdata !== 32'h0) begin failures++; $display("FAIL rst_mem_wdata got=%0h exp=0", bus.mem_wdata); end
        checks++; if (cpu_rst !== 1'b1) begin failures++; $display("FAIL rst_cpu_rst got=%0h exp=1", cpu_rst); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%0h exp=0", done); end
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL rst_error got=%0h exp=0", error); end
        checks++; if (word_count !== 4'd0) begin failures++; $display("FAIL rst_word_count got=%0d exp=0", word_count); end
    endtask

    task automatic test_back_to_back();
        int n;
        do_reset();
        clear_q();
        bus.in_valid = 1'b1; bus.in_data = 32'hA; bus.in_last = 1'b0;
        step();
        bus.in_data = 32'hB;
        step();
        bus.in_data = 32'hC; bus.in_last = 1'b1;
        step();                                  // edge L
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        checks++; if (bus.mem_wen !== 1'b1) begin failures++; $display("FAIL b2b_wen_L got=%0h exp=1", bus.mem_wen); end
        checks++; if (bus.mem_waddr !== 32'd2) begin failures++; $display("FAIL b2b_waddr_L got=%0h exp=2", bus.mem_waddr); end
        checks++; if (bus.mem_wdata !== 32'hC) begin failures++; $display("FAIL b2b_wdata_L got=%0h exp=c", bus.mem_wdata); end
        checks++; if (word_count !== 4'd3) begin failures++; $display("FAIL b2b_word_count got=%0d exp=3", word_count); end
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL b2b_in_ready_hold got=%0h exp=0", bus.in_ready); end
        step();                                  // L+1
        checks++; if (bus.mem_wen !== 1'b0) begin failures++; $display("FAIL b2b_wen_L1 got=%0h exp=0", bus.mem_wen); end
        checks++; if (cpu_rst !== 1'b1) begin failures++; $display("FAIL b2b_cpu_rst_L1 got=%0h exp=1", cpu_rst); end
        n = 1;
        while (cpu_rst === 1'b1 && n < 20) begin step(); n++; end
        checks++; if (n !== 5) begin failures++; $display("FAIL b2b_release_delay got=%0d exp=5", n); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_done got=%0h exp=1", done); end
        checks++; if (q_addr.size() !== 3) begin failures++; $display("FAIL b2b_write_count got=%0d exp=3", q_addr.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (q_addr[i] !== i) begin failures++; $display("FAIL b2b_addr%0d got=%0h exp=%0h", i, q_addr[i], i); end
                checks++; if (q_data[i] !== 32'hA + i) begin failures++; $display("FAIL b2b_data%0d got=%0h exp=%0h", i, q_data[i], 32'hA + i); end
                checks++; if (q_cyc[i] - q_cyc[0] !== i) begin failures++; $display("FAIL b2b_cycle%0d got=%0d exp=%0d", i, q_cyc[i] - q_cyc[0], i); end
            end
        end
    endtask

    task automatic test_gaps();
        do_reset();
        clear_q();
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 32'h100 + i; bus.in_last = 1'b0;
            step();
            checks++; if (bus.mem_wen !== 1'b1 || bus.mem_waddr !== i) begin failures++; $display("FAIL gap_beat%0d got=wen%0h/addr%0h exp=wen1/addr%0h", i, bus.mem_wen, bus.mem_waddr, i); end
            bus.in_valid = 1'b0; bus.in_last = 1'b1;     // in_last without in_valid
            step();
            checks++; if (bus.mem_wen !== 1'b0) begin failures++; $display("FAIL gap_off1_%0d got=%0h exp=0", i, bus.mem_wen); end
            checks++; if (bus.in_ready !== 1'b1 || word_count !== 4'(i + 1)) begin failures++; $display("FAIL gap_state%0d got=rdy%0h/wc%0d exp=rdy1/wc%0d", i, bus.in_ready, word_count, i + 1); end
            bus.in_last = 1'b0;
            step();
            checks++; if (bus.mem_wen !== 1'b0) begin failures++; $display("FAIL gap_off2_%0d got=%0h exp=0", i, bus.mem_wen); end
        end
        checks++; if (q_addr.size() !== 4) begin failures++; $display("FAIL gap_write_count got=%0d exp=4", q_addr.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (q_addr[i] !== i || q_data[i] !== 32'h100 + i) begin failures++; $display("FAIL gap_write%0d got=%0h:%0h exp=%0h:%0h", i, q_addr[i], q_data[i], i, 32'h100 + i); end
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        clear_q();
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 32'h200 + i; bus.in_last = 1'b0;
            step();
        end
        bus.in_valid = 1'b0;
        checks++; if (error !== 1'b1) begin failures++; $display("FAIL ovf_error got=%0h exp=1", error); end
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL ovf_in_ready got=%0h exp=0", bus.in_ready); end
        checks++; if (cpu_rst !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL ovf_cpu got=rst%0h/done%0h exp=rst1/done0", cpu_rst, done); end
        checks++; if (word_count !== 4'd8) begin failures++; $display("FAIL ovf_word_count got=%0d exp=8", word_count); end
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus.mem_wen !== 1'b0 || error !== 1'b1) begin failures++; $display("FAIL ovf_hold%0d got=wen%0h/err%0h exp=wen0/err1", i, bus.mem_wen, error); end
        end
        bus.in_valid = 1'b0;
        checks++; if (q_addr.size() !== 8) begin failures++; $display("FAIL ovf_write_count got=%0d exp=8", q_addr.size()); end
        else begin
            for (int i = 0; i < 8; i++) begin
                checks++; if (q_addr[i] !== i || q_data[i] !== 32'h200 + i) begin failures++; $display("FAIL ovf_write%0d got=%0h:%0h exp=%0h:%0h", i, q_addr[i], q_data[i], i, 32'h200 + i); end
            end
        end
    endtask

    task automatic test_full_last();
        int n;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 32'h300 + i; bus.in_last = (i == 7);
            step();
        end
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL full_error got=%0h exp=0", error); end
        checks++; if (bus.mem_waddr !== 32'd7 || word_count !== 4'd8) begin failures++; $display("FAIL full_last_write got=addr%0h/wc%0d exp=addr7/wc8", bus.mem_waddr, word_count); end
        n = 0;
        while (done !== 1'b1 && n < 20) begin step(); n++; end
        checks++; if (n !== 5) begin failures++; $display("FAIL full_release got=%0d exp=5", n); end
        checks++; if (cpu_rst !== 1'b0 || error !== 1'b0) begin failures++; $display("FAIL full_run got=rst%0h/err%0h exp=rst0/err0", cpu_rst, error); end
    endtask

    task automatic test_reset_mid();
        bus.in_valid = 1'b1; bus.in_data = 32'h50; bus.in_last = 1'b0;
        do_reset();
        bus.in_valid = 1'b1; bus.in_data = 32'h50; bus.in_last = 1'b0;
        step();
        bus.in_data = 32'h51; bus.in_last = 1'b1;
        step();
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        step();                                   // in HOLD
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (bus.in_ready !== 1'b1 || word_count !== 4'd0) begin failures++; $display("FAIL mid_rst_ready got=rdy%0h/wc%0d exp=rdy1/wc0", bus.in_ready, word_count); end
        checks++; if (cpu_rst !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin failures++; $display("FAIL mid_rst_status got=%0h%0h%0h exp=100", cpu_rst, done, error); end
        checks++; if (bus.mem_wen !== 1'b0 || bus.mem_waddr !== 32'h0 || bus.mem_wdata !== 32'h0) begin failures++; $display("FAIL mid_rst_mem got=%0h/%0h/%0h exp=0/0/0", bus.mem_wen, bus.mem_waddr, bus.mem_wdata); end
        clear_q();
        bus.in_valid = 1'b1; bus.in_data = 32'h77; bus.in_last = 1'b1;
        step();
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        checks++; if (bus.mem_wen !== 1'b1 || bus.mem_waddr !== 32'h0 || bus.mem_wdata !== 32'h77) begin failures++; $display("FAIL mid_reload got=%0h/%0h/%0h exp=1/0/77", bus.mem_wen, bus.mem_waddr, bus.mem_wdata); end
        repeat (5) step();
        checks++; if (done !== 1'b1 || cpu_rst !== 1'b0) begin failures++; $display("FAIL mid_reload_run got=done%0h/rst%0h exp=done1/rst0", done, cpu_rst); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (done !== 1'b0 || cpu_rst !== 1'b1 || bus.in_ready !== 1'b1 || word_count !== 4'd0) begin failures++; $display("FAIL run_rst got=done%0h/rst%0h/rdy%0h/wc%0d exp=0/1/1/0", done, cpu_rst, bus.in_ready, word_count); end
        checks++; if (q_addr.size() !== 1) begin failures++; $display("FAIL mid_reload_writes got=%0d exp=1", q_addr.size()); end
    endtask

    task automatic test_run_ignore();
        do_reset();
        bus.in_valid = 1'b1; bus.in_data = 32'h400; bus.in_last = 1'b1;
        step();
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        repeat (5) step();
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL run_entry got=%0h exp=1", done); end
        clear_q();
        bus.in_valid = 1'b1; bus.in_data = 32'hDEAD; bus.in_last = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++; if (bus.mem_wen !== 1'b0 || word_count !== 4'd1 || done !== 1'b1) begin failures++; $display("FAIL run_ignore%0d got=wen%0h/wc%0d/done%0h exp=wen0/wc1/done1", i, bus.mem_wen, word_count, done); end
        end
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        step();
        checks++; if (q_addr.size() !== 0) begin failures++; $display("FAIL run_ignore_writes got=%0d exp=0", q_addr.size()); end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_data = '0;
        test_reset();
        test_back_to_back();
        test_gaps();
        test_overflow();
        test_full_last();
        test_reset_mid();
        test_run_ignore();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
